// File: rtl/parking_lot_ctrl_pkg.sv
// Shared types and default sizing for the parking lot controller.
// Enum names are bare (IDLE/OPEN/HOLD); import only where the gate FSM is needed.
package lot_pkg;

  typedef enum logic [1:0] {IDLE, OPEN, HOLD} gate_state_t;

  localparam int DEF_CAPACITY     = 200;
  localparam int DEF_CNT_W        = 8;
  localparam int DEF_GATE_TIMEOUT = 1000;
  localparam int DEF_CLOSE_HOLD   = 4;

endpackage

// File: rtl/parking_lot_ctrl_if.sv
// Detector pulses, entry request and occupancy/gate status of the lot controller.
// master drives detectors and requests; slave is the controller.
interface parking_lot_ctrl_if #(parameter int CNT_W = 8);
  logic             inc_a, dec_a, inc_b, dec_b;
  logic             req_entry, err_clr;
  logic             gate_open;
  logic [CNT_W-1:0] count;
  logic             full, empty, err_ovf, err_udf;

  modport master (
    output inc_a, dec_a, inc_b, dec_b, req_entry, err_clr,
    input  gate_open, count, full, empty, err_ovf, err_udf
  );

  modport slave (
    input  inc_a, dec_a, inc_b, dec_b, req_entry, err_clr,
    output gate_open, count, full, empty, err_ovf, err_udf
  );
endinterface

// File: rtl/parking_lot_ctrl_gate_fsm.sv
// Entrance barrier FSM: IDLE -> OPEN on request with room, OPEN -> HOLD on entry
// or timeout, HOLD -> IDLE after CLOSE_HOLD cycles.
module lot_gate_fsm
  import lot_pkg::*;
#(
  parameter int GATE_TIMEOUT = DEF_GATE_TIMEOUT,
  parameter int CLOSE_HOLD   = DEF_CLOSE_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic req_entry,
  input  logic inc_a,
  input  logic has_room,
  output logic gate_open
);
  localparam int TW = (GATE_TIMEOUT > 1) ? $clog2(GATE_TIMEOUT) : 1;
  localparam int HW = (CLOSE_HOLD > 1) ? $clog2(CLOSE_HOLD) : 1;

  gate_state_t   state;
  logic [TW-1:0] open_t;
  logic [HW-1:0] hold_t;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      open_t    <= '0;
      hold_t    <= '0;
      gate_open <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_entry && has_room) begin
          state     <= OPEN;
          open_t    <= '0;
          gate_open <= 1'b1;
        end
        // open_t counts completed open cycles; the last one closes the gate
        OPEN: if (inc_a || open_t == TW'(GATE_TIMEOUT - 1)) begin
          state     <= HOLD;
          hold_t    <= '0;
          gate_open <= 1'b0;
        end else begin
          open_t <= open_t + 1'b1;
        end
        HOLD: if (hold_t == HW'(CLOSE_HOLD - 1)) state <= IDLE;
              else                                 hold_t <= hold_t + 1'b1;
        default: begin
          state     <= IDLE;
          gate_open <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/parking_lot_ctrl.sv
// Parking lot occupancy counter with saturation and a gated-entrance FSM.
// Define LOT_CTRL_ERR_EN to enable sticky err_ovf/err_udf flags cleared by err_clr.
module parking_lot_ctrl
  import lot_pkg::*;
#(
  parameter int CAPACITY     = DEF_CAPACITY,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int GATE_TIMEOUT = DEF_GATE_TIMEOUT,
  parameter int CLOSE_HOLD   = DEF_CLOSE_HOLD
) (
  input  logic               clk,
  input  logic               rst,
  parking_lot_ctrl_if.slave  bus
);
  localparam int SW = CNT_W + 2;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic signed [SW-1:0] nxt;
  logic                 ovf_evt, udf_evt;
  logic                 gate_q;

  // Two extra bits hold the -2..CAPACITY+2 range of count + delta
  always_comb begin
    nxt = signed'({2'b00, cnt_q})
        + signed'(SW'(bus.inc_a)) + signed'(SW'(bus.inc_b))
        - signed'(SW'(bus.dec_a)) - signed'(SW'(bus.dec_b));
    ovf_evt = nxt > signed'(SW'(CAPACITY));
    udf_evt = nxt[SW-1];
    cnt_d   = nxt[CNT_W-1:0];
    if (ovf_evt)      cnt_d = CNT_W'(CAPACITY);
    else if (udf_evt) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.count     = cnt_q;
  assign bus.full      = (cnt_q == CNT_W'(CAPACITY));
  assign bus.empty     = (cnt_q == '0);
  assign bus.gate_open = gate_q;

`ifdef LOT_CTRL_ERR_EN
  logic ovf_q, udf_q;

  // A new error in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_evt)          ovf_q <= 1'b1;
      else if (bus.err_clr) ovf_q <= 1'b0;
      if (udf_evt)          udf_q <= 1'b1;
      else if (bus.err_clr) udf_q <= 1'b0;
    end
  end

  assign bus.err_ovf = ovf_q;
  assign bus.err_udf = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.err_ovf    = 1'b0;
  assign bus.err_udf    = 1'b0;
`endif

  lot_gate_fsm #(
    .GATE_TIMEOUT (GATE_TIMEOUT),
    .CLOSE_HOLD   (CLOSE_HOLD)
  ) u_gate (
    .clk       (clk),
    .rst       (rst),
    .req_entry (bus.req_entry),
    .inc_a     (bus.inc_a),
    .has_room  (cnt_q < CNT_W'(CAPACITY)),
    .gate_open (gate_q)
  );
endmodule

// File: doc/parking_lot_ctrl.md
PARKING_LOT_CTRL -- requirements
Module: parking_lot_ctrl

Interface
REQ-001 Parameter CAPACITY, default 200; maximum occupancy of the lot.
REQ-002 Parameter CNT_W, default 8; occupancy counter width; CAPACITY SHALL be at most 2**CNT_W-1.
REQ-003 Parameter GATE_TIMEOUT, default 1000; cycles the gate stays open waiting for an entry.
REQ-004 Parameter CLOSE_HOLD, default 4; minimum cycles the gate stays closed before it can reopen.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 inc_a, dec_a  in  1 each  single-cycle entry/exit pulses from the gated-entrance car detector.
REQ-008 inc_b, dec_b  in  1 each  single-cycle entry/exit pulses from the ungated side-lane car detector.
REQ-009 req_entry  in  1  level; a car is waiting at the gated entrance.
REQ-010 err_clr  in  1  pulse; clears the sticky error flags (only with LOT_CTRL_ERR_EN).
REQ-011 gate_open  out  1  registered; entrance barrier raised.
REQ-012 count  out  CNT_W  registered occupancy.
REQ-013 full, empty  out  1 each  count==CAPACITY, count==0; decoded from the registered count.
REQ-014 err_ovf, err_udf  out  1 each  sticky overflow/underflow flags.

Function
REQ-015 Per cycle, net delta = (inc_a+inc_b) - (dec_a+dec_b), range -2..+2; count SHALL update on the edge following the pulses (1-cycle latency).
REQ-016 Simultaneous inc and dec in the same cycle SHALL net out; for example inc_a with dec_b leaves count unchanged.
REQ-017 If count+delta exceeds CAPACITY, count SHALL saturate at CAPACITY and err_ovf SHALL set.
REQ-018 If count+delta is below 0, count SHALL saturate at 0 and err_udf SHALL set.
REQ-019 Gate FSM states: IDLE, OPEN, HOLD.
REQ-020 IDLE->OPEN when req_entry=1 and count<CAPACITY; gate_open=1 on the next edge.
REQ-021 While OPEN, one slot is reserved: a further entry via inc_b that makes count==CAPACITY SHALL NOT close the gate, but the FSM SHALL NOT reopen from IDLE until count<CAPACITY.
REQ-022 OPEN->HOLD on inc_a, or when the open timer reaches GATE_TIMEOUT; gate_open=0 on that edge.
REQ-023 The open timer SHALL reset to 0 on entry to OPEN.
REQ-024 HOLD->IDLE after exactly CLOSE_HOLD cycles in HOLD; req_entry SHALL be ignored during HOLD.
REQ-025 inc_a while not OPEN SHALL still count (tailgating) and SHALL NOT change FSM state.
REQ-026 The full output SHALL NOT force the gate closed while in OPEN.

Reset
REQ-027 On rst: count=0, FSM=IDLE, timers=0, gate_open=0, err_ovf=err_udf=0; empty=1, full=0.
REQ-028 rst asserted mid-OPEN SHALL drop gate_open on the same edge; inc/dec pulses in reset cycles SHALL be discarded.

Configuration
REQ-029 Macro LOT_CTRL_ERR_EN defined: err_ovf/err_udf are sticky until err_clr or rst; if err_clr coincides with a new error, the error SHALL win.
REQ-030 LOT_CTRL_ERR_EN undefined: err_ovf/err_udf SHALL be tied 0 and err_clr ignored; saturation per REQ-017/018 SHALL be retained.

Structure
REQ-031 Package lot_pkg SHALL hold the gate_state_t enum (IDLE, OPEN, HOLD) and the default CAPACITY, GATE_TIMEOUT and CLOSE_HOLD constants.
REQ-032 The gate FSM and its timers SHALL be the sub-module lot_gate_fsm; occupancy arithmetic SHALL live in the top level.

Verification
REQ-033 Reset, then req_entry=1 -> gate_open=1 one cycle later; inc_a pulse -> gate_open=0 and count=1 on the next edge; 4 HOLD cycles, then reopen if req_entry is still 1.
REQ-034 CAPACITY=3 with three entries -> full=1; req_entry=1 -> gate stays 0; dec_b -> count=2, then the gate opens.
REQ-035 count=5, inc_a and inc_b in the same cycle with dec_b -> count=6; inc_b with dec_a -> count stays 6.
REQ-036 count=0, dec_a and dec_b together -> count=0 and err_udf=1 with macro defined; err_clr -> err_udf=0; with macro undefined, err_udf stays 0.
REQ-037 GATE_TIMEOUT=10, gate opened with no inc_a -> gate_open falls exactly 10 cycles after rising; count unchanged.
REQ-038 rst during OPEN with a simultaneous inc_a -> gate_open=0, count=0 next edge, no error set.
